dmem_controller: RTL and testbench

DMEM_CONTROLLER -- requirements
Module: dmem_controller

---
 rtl/dmem_controller.sv | 163 ++++++++++++++++
 tb/tb_dmem_controller.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_controller.sv
// Data-memory controller: turns Memory-stage load/store requests into
// single-port SRAM accesses with byte lanes, fault checks and load extension.
module dmem_controller #(
  parameter int ADDR_WIDTH = 12,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  dmem_WE,
  input  logic [2:0]            dmem_SEL,
  input  logic [31:0]           addr,
  input  logic [31:0]           wdata,
  output logic                  busy,
  output logic                  resp_valid,
  output logic                  fault,
  output logic [31:0]           rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  // Latched request; only the in-range address bits are kept, the upper
  // bits matter solely for the range fault decided at accept time.
  typedef struct packed {
    logic                  we;
    logic [2:0]            sel;
    logic [ADDR_WIDTH+1:0] addr;
    logic [31:0]           wdata;
  } req_t;

  localparam logic [2:0]  LAT        = 3'(RD_LATENCY);
  localparam logic [31:0] RANGE_MASK = ~((32'd1 << (ADDR_WIDTH + 2)) - 32'd1);

  state_t      state, state_nxt;
  logic [2:0]  cnt, cnt_nxt;
  req_t        req_q;
  logic        accept, sample, req_bad;
  logic        sel_bad, align_bad, range_bad;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_val;

  // Fault classification of the live request (only used on the accept edge)
  always_comb begin
    sel_bad   = dmem_WE ? (dmem_SEL > 3'd2)
                        : (dmem_SEL inside {3'b011, 3'b100, 3'b111});
    align_bad = ((dmem_SEL[1:0] == 2'b01) && addr[0]) ||
                ((dmem_SEL[1:0] == 2'b00) && (addr[1:0] != 2'b00));
    range_bad = |(addr & RANGE_MASK);
    req_bad   = sel_bad || align_bad || range_bad;
  end

  // Next-state logic and WAIT down-counter
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    sample    = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept    = 1'b1;
          state_nxt = req_bad ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (req_q.we) begin
          state_nxt = DONE;
        end else begin
          state_nxt = WAIT;
          cnt_nxt   = LAT;
        end
      end
      WAIT: begin
        if (cnt == 3'd1) begin
          sample    = 1'b1;
          state_nxt = DONE;
          cnt_nxt   = 3'd0;
        end else begin
          cnt_nxt = cnt - 3'd1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Load extraction from the returned SRAM word
  always_comb begin
    case (req_q.addr[1:0])
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = req_q.addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (req_q.sel)
      3'b110:  load_val = {{24{ld_byte[7]}}, ld_byte};
      3'b010:  load_val = {24'd0, ld_byte};
      3'b101:  load_val = {{16{ld_half[15]}}, ld_half};
      3'b001:  load_val = {16'd0, ld_half};
      default: load_val = mem_rdata;
    endcase
  end

  // Store lane steering; loads read the whole word and drive no data
  always_comb begin
    mem_be    = 4'b1111;
    mem_wdata = 32'd0;
    if (req_q.we) begin
      case (req_q.sel[1:0])
        2'b10: begin
          mem_be    = 4'b0001 << req_q.addr[1:0];
          mem_wdata = {4{req_q.wdata[7:0]}};
        end
        2'b01: begin
          mem_be    = req_q.addr[1] ? 4'b1100 : 4'b0011;
          mem_wdata = {2{req_q.wdata[15:0]}};
        end
        default: begin
          mem_be    = 4'b1111;
          mem_wdata = req_q.wdata;
        end
      endcase
    end
  end

  // SRAM strobes are gated by reset so an aborted access never reaches memory
  always_comb begin
    mem_en     = (state == ISSUE) && reset;
    mem_we     = (state == ISSUE) && reset && req_q.we;
    mem_addr   = req_q.addr[ADDR_WIDTH+1:2];
    busy       = (state != IDLE);
    resp_valid = (state == DONE);
  end

  // State, request latch, fault flag and load result registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 3'd0;
      req_q <= '0;
      fault <= 1'b0;
      rdata <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        req_q <= '{we: dmem_WE, sel: dmem_SEL,
                   addr: addr[ADDR_WIDTH+1:0], wdata: wdata};
        fault <= req_bad;
      end
      if (sample) rdata <= load_val;
    end
  end

endmodule

// File: tb/tb_dmem_controller.sv
// Bench for dmem_controller: two instances (read latency 1 and 4) share the
// request inputs; each has its own SRAM model. Expected results come from a
// byte-addressed reference memory and the access rules.
module tb_dmem_controller;
  localparam int AW = 12;

  logic        clk = 1'b0, reset = 1'b0, req_valid = 1'b0, dmem_WE = 1'b0;
  logic [2:0]  dmem_SEL = 3'd0;
  logic [31:0] addr = 32'd0, wdata = 32'd0;

  logic          busy1, rv1, f1, en1, we1, busy4, rv4, f4, en4, we4;
  logic [31:0]   rd1, wd1, mrd1, rd4, wd4, mrd4;
  logic [AW-1:0] ma1, ma4;
  logic [3:0]    be1, be4;

  always #5 clk = ~clk;

  dmem_controller #(.ADDR_WIDTH(AW), .RD_LATENCY(1)) u1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .dmem_WE(dmem_WE),
    .dmem_SEL(dmem_SEL), .addr(addr), .wdata(wdata), .busy(busy1),
    .resp_valid(rv1), .fault(f1), .rdata(rd1), .mem_en(en1), .mem_we(we1),
    .mem_addr(ma1), .mem_be(be1), .mem_wdata(wd1), .mem_rdata(mrd1));

  dmem_controller #(.ADDR_WIDTH(AW), .RD_LATENCY(4)) u4 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .dmem_WE(dmem_WE),
    .dmem_SEL(dmem_SEL), .addr(addr), .wdata(wdata), .busy(busy4),
    .resp_valid(rv4), .fault(f4), .rdata(rd4), .mem_en(en4), .mem_we(we4),
    .mem_addr(ma4), .mem_be(be4), .mem_wdata(wd4), .mem_rdata(mrd4));

  // SRAM models: byte-enabled write, read data delayed by 1 or 4 edges
  logic [31:0] sram1 [0:4095] = '{default: 32'd0};
  logic [31:0] sram4 [0:4095] = '{default: 32'd0};
  logic [31:0] rp1 = 32'd0;
  logic [31:0] rp4 [1:4] = '{default: 32'd0};
  assign mrd1 = rp1;
  assign mrd4 = rp4[4];

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (en1 && we1 && be1[i]) sram1[ma1][8*i +: 8] <= wd1[8*i +: 8];
    if (en1 && !we1) rp1 <= sram1[ma1];
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (en4 && we4 && be4[i]) sram4[ma4][8*i +: 8] <= wd4[8*i +: 8];
    if (en4 && !we4) rp4[1] <= sram4[ma4];
    for (int s = 2; s <= 4; s++) rp4[s] <= rp4[s-1];
  end

  // Reference model state
  logic [7:0]    rmem [0:1023] = '{default: 8'h00};
  logic [31:0]   ref_rdata = 32'd0;
  int            checks = 0, errors = 0;
  logic [31:0]   last_r1, last_r4, last_wd;
  logic [AW-1:0] last_ma;
  logic [3:0]    last_be;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic int acc_size(input logic [2:0] sel);
    case (sel[1:0])
      2'b00:   return 4;
      2'b01:   return 2;
      default: return 1;
    endcase
  endfunction

  function automatic bit ref_fault(input logic we, input logic [2:0] sel, input logic [31:0] a);
    bit illegal;
    illegal = we ? !(sel inside {3'd0, 3'd1, 3'd2})
                 : !(sel inside {3'd0, 3'd1, 3'd2, 3'd5, 3'd6});
    return illegal || (a % acc_size(sel) != 0) || (a >= 32'd16384);
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] sel, input int a);
    int sz;
    logic [31:0] v;
    sz = acc_size(sel);
    v  = 32'd0;
    for (int i = 0; i < sz; i++) v[8*i +: 8] = rmem[a+i];
    if (sel[2] && v[8*sz-1])
      for (int i = 8*sz; i < 32; i++) v[i] = 1'b1;
    return v;
  endfunction

  task automatic ref_store(input logic [2:0] sel, input int a, input logic [31:0] wd);
    for (int i = 0; i < acc_size(sel); i++) rmem[a+i] = wd[8*i +: 8];
  endtask

  // One request through both instances, checked against the reference model
  task automatic do_req(input logic we, input logic [2:0] sel, input logic [31:0] a,
                        input logic [31:0] wd);
    bit f;
    int sz, ai, e1, e4, l1, l4;
    logic [3:0] xbe, cbe;
    logic [31:0] xwd, cwd, r1, r4;
    logic fo1, fo4, s1, s4, cwe;
    logic [AW-1:0] cma;
    f  = ref_fault(we, sel, a);
    sz = acc_size(sel);
    ai = int'(a[1:0]);
    e1 = f ? 1 : (we ? 2 : 3);
    e4 = f ? 1 : (we ? 2 : 6);
    xbe = 4'h0; xwd = 32'd0;
    if (we) begin
      for (int i = 0; i < sz; i++) xbe[ai+i] = 1'b1;
      for (int l = 0; l < 4; l++) xwd[8*l +: 8] = wd[8*(l % sz) +: 8];
    end else xbe = 4'hF;
    l1 = 0; l4 = 0; fo1 = 0; fo4 = 0; r1 = 0; r4 = 0; s1 = 0; s4 = 0;
    cma = '0; cwe = 0; cbe = 0; cwd = 0;
    @(negedge clk);
    req_valid = 1'b1; dmem_WE = we; dmem_SEL = sel; addr = a; wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; dmem_WE = 1'($urandom); dmem_SEL = 3'($urandom);
    addr = $urandom; wdata = $urandom;
    for (int k = 1; k <= 10; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      if (k == 1) chk("busy_after_accept", 32'(busy1 & busy4), 32'd1);
      if (en1) begin s1 = 1; cma = ma1; cwe = we1; cbe = be1; cwd = wd1; end
      if (en4) s4 = 1;
      if (rv1 && l1 == 0) begin l1 = k; fo1 = f1; r1 = rd1; end
      if (rv4 && l4 == 0) begin l4 = k; fo4 = f4; r4 = rd4; end
      if (l1 != 0 && l4 != 0) break;
    end
    @(posedge clk); #1;
    if (!f) begin
      if (we) ref_store(sel, int'(a[9:0]), wd);
      else    ref_rdata = ref_load(sel, int'(a[9:0]));
    end
    chk("latency_rl1", 32'(l1), 32'(e1));
    chk("latency_rl4", 32'(l4), 32'(e4));
    chk("fault_rl1", 32'(fo1), 32'(f));
    chk("fault_rl4", 32'(fo4), 32'(f));
    chk("rdata_rl1", r1, ref_rdata);
    chk("rdata_rl4", r4, ref_rdata);
    chk("mem_en_seen_rl1", 32'(s1), 32'(!f));
    chk("mem_en_seen_rl4", 32'(s4), 32'(!f));
    chk("idle_after_done", 32'({busy1, busy4}), 32'd0);
    if (!f) begin
      chk("mem_addr", 32'(cma), 32'(a[AW+1:2]));
      chk("mem_we", 32'(cwe), 32'(we));
      chk("mem_be", 32'(cbe), 32'(xbe));
      chk("mem_wdata", cwd, xwd);
    end
    last_r1 = r1; last_r4 = r4; last_ma = cma; last_be = cbe; last_wd = cwd;
  endtask

  initial begin
    logic [6:0] pat1, pat4;
    logic [AW-1:0] b2b_ma;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'({busy1, busy4}), 32'd0);
    chk("rst_resp_valid", 32'({rv1, rv4}), 32'd0);
    chk("rst_fault", 32'({f1, f4}), 32'd0);
    chk("rst_rdata", rd1 | rd4, 32'd0);
    chk("rst_mem_en", 32'({en1, en4, we1, we4}), 32'd0);
    @(negedge clk); reset = 1'b1;

    // Directed: word store, byte store/loads, halfword loads
    do_req(1'b1, 3'b000, 32'h10, 32'hDEADBEEF);
    chk("sw_mem_addr", 32'(last_ma), 32'd4);
    chk("sw_mem_be", 32'(last_be), 32'hF);
    chk("sw_mem_wdata", last_wd, 32'hDEADBEEF);
    do_req(1'b1, 3'b010, 32'h13, 32'h000000A5);
    chk("sb_mem_be", 32'(last_be), 32'h8);
    chk("sb_mem_wdata", last_wd, 32'hA5A5A5A5);
    do_req(1'b0, 3'b110, 32'h13, 32'h0);
    chk("lb_value", last_r1, 32'hFFFFFFA5);
    do_req(1'b0, 3'b010, 32'h13, 32'h0);
    chk("lbu_value", last_r4, 32'h000000A5);
    do_req(1'b1, 3'b000, 32'h0, 32'h80017FFF);
    do_req(1'b0, 3'b101, 32'h2, 32'h0);
    chk("lh_hi_value", last_r1, 32'hFFFF8001);
    do_req(1'b0, 3'b001, 32'h2, 32'h0);
    chk("lhu_hi_value", last_r4, 32'h00008001);
    do_req(1'b0, 3'b101, 32'h0, 32'h0);
    chk("lh_lo_value", last_r1, 32'h00007FFF);

    // Directed faults: rdata must keep the last load result
    do_req(1'b0, 3'b000, 32'h6, 32'h0);
    do_req(1'b1, 3'b001, 32'h1, 32'h1234);
    do_req(1'b0, 3'b110, 32'h4000, 32'h0);
    do_req(1'b0, 3'b011, 32'h0, 32'h0);
    chk("fault_keeps_rdata", last_r1, 32'h00007FFF);

    // Randomized requests
    for (int n = 0; n < 40; n++) begin
      logic [31:0] ra;
      ra = ($urandom_range(0, 9) == 0) ? (32'h4000 << $urandom_range(0, 17)) | 32'($urandom_range(0, 63))
                                       : 32'($urandom_range(0, 63));
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra, $urandom);
    end

    // Back-to-back: request held high, address changes every cycle
    @(negedge clk);
    req_valid = 1'b1; dmem_WE = 1'b1; dmem_SEL = 3'b000; addr = 32'h100; wdata = 32'd0;
    pat1 = '0; pat4 = '0; b2b_ma = '0;
    for (int j = 0; j < 7; j++) begin
      @(posedge clk); #1;
      pat1[j] = en1; pat4[j] = en4;
      if (j == 3) b2b_ma = ma1;
      @(negedge clk);
      addr = 32'h100 + 32'(4 * (j + 1)); wdata = 32'(j + 1);
    end
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("b2b_issue_pattern_rl1", 32'(pat1), 32'b1001001);
    chk("b2b_issue_pattern_rl4", 32'(pat4), 32'b1001001);
    chk("b2b_second_addr", 32'(b2b_ma), 32'h43);
    ref_store(3'b000, 32'h100, 32'd0);
    ref_store(3'b000, 32'h10C, 32'd3);
    ref_store(3'b000, 32'h118, 32'd6);
    do_req(1'b0, 3'b000, 32'h10C, 32'h0);
    chk("b2b_stored_word", last_r1, 32'd3);
    do_req(1'b0, 3'b000, 32'h10, 32'h0);

    // Reset during WAIT of a load
    @(negedge clk);
    req_valid = 1'b1; dmem_WE = 1'b0; dmem_SEL = 3'b000; addr = 32'h10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("wait_rst_busy", 32'({busy1, busy4}), 32'd0);
    chk("wait_rst_resp", 32'({rv1, rv4}), 32'd0);
    chk("wait_rst_rdata", rd1 | rd4, 32'd0);
    @(negedge clk); reset = 1'b1;
    ref_rdata = 32'd0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("no_resp_after_abort", 32'({rv1, rv4}), 32'd0);
    end

    // Reset during ISSUE of a store: strobes drop at once, no write happens
    @(negedge clk);
    req_valid = 1'b1; dmem_WE = 1'b1; dmem_SEL = 3'b000; addr = 32'h20; wdata = 32'h11111111;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("issue_mem_en", 32'(en1 & en4), 32'd1);
    reset = 1'b0;
    #1;
    chk("issue_rst_mem_en", 32'({en1, en4, we1, we4}), 32'd0);
    @(posedge clk); #1;
    chk("issue_rst_busy", 32'({busy1, busy4}), 32'd0);
    @(negedge clk); reset = 1'b1;
    do_req(1'b0, 3'b000, 32'h20, 32'h0);

    // Reset wins over a request at the same edge
    @(negedge clk);
    reset = 1'b0; req_valid = 1'b1; dmem_WE = 1'b0; dmem_SEL = 3'b000; addr = 32'h0;
    @(posedge clk); #1;
    chk("rst_priority_busy", 32'({busy1, busy4}), 32'd0);
    @(negedge clk);
    reset = 1'b1; req_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_priority_idle", 32'({busy1, busy4, rv1, rv4}), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
